// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl: runs an external 1-bit ALU slice LSB-first for WIDTH cycles with a registered carry; ALU_CTRL_FLAGS_EN adds zero/overflow flags
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_n;
  logic [2:0] op_q;
  logic [CW-1:0] cnt;
  logic carry, arith, last, run;
  assign run = state == RUN;
  assign arith = op_q == 3'd2 || op_q == 3'd3;
  assign last = cnt == CW'(WIDTH - 1);
  assign res_n = {alu_result, res_sh[WIDTH-1:1]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign alu_a = run & a_sh[0];
  assign alu_b = run & b_sh[0];
  assign alu_cin = run & carry;
  assign alu_op = run ? op_q : 3'd0;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (run) state_n = last ? DONE : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      res_sh <= '0;
      op_q <= 3'd0;
      cnt <= '0;
      carry <= 1'b0;
      result <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        a_sh <= a_in;
        b_sh <= b_in;
        op_q <= op;
        cnt <= '0;
        carry <= op == 3'd3;
      end else if (run) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res_sh <= res_n;
        carry <= arith & alu_cout;
        cnt <= cnt + 1'b1;
        if (last) begin
          result <= res_n;
          c_out <= arith & alu_cout;
        end
      end
    end
  end
`ifdef ALU_CTRL_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else if (run && last) begin
      zero_flag <= res_n == '0;
      ovf_flag <= arith & (carry ^ alu_cout);
    end
  end
`else
  assign zero_flag = 1'b0;
  assign ovf_flag = 1'b0;
`endif
endmodule
